br_resolve: RTL and testbench

BR_RESOLVE -- requirements
Module: br_resolve

---
 rtl/br_pkg.sv | 38 +++
 rtl/br_cond.sv | 23 ++
 rtl/br_resolve.sv | 184 ++++++++++++++++++
 tb/tb_br_resolve.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types for branch resolution: FSM states, funct3 codes, transfer-class priority.
package br_pkg;

    localparam int unsigned STAT_WIDTH = 32;

    // Redirect / flush sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH2   = 2'd2
    } state_e;

    // Branch condition codes (funct3)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Resolved control-transfer class
    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_JAL    = 2'd2,
        CLS_JALR   = 2'd3
    } cls_e;

    // Class priority: JALR over JAL over conditional branch
    function automatic cls_e cls_encode(input logic is_branch, input logic is_jal,
                                        input logic is_jalr);
        if (is_jalr)        return CLS_JALR;
        else if (is_jal)    return CLS_JAL;
        else if (is_branch) return CLS_BRANCH;
        else                return CLS_NONE;
    endfunction

endpackage

// File: rtl/br_cond.sv
// Branch condition decode from funct3 and comparator flags.
module br_cond
    import br_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       taken_c
);

    // Map condition code to taken; reserved codes never take
    always_comb begin
        taken_c = 1'b0;
        case (funct3)
            F3_BEQ:           taken_c = equal;
            F3_BNE:           taken_c = ~equal;
            F3_BLT, F3_BLTU:  taken_c = less;
            F3_BGE, F3_BGEU:  taken_c = ~less;
            default:          taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_resolve.sv
// EX-stage branch/jump resolution: mispredict detection, registered fetch redirect,
// two-cycle front-end flush and predictor update.
// Optional macro BR_RESOLVE_STATS_EN adds saturating branch/mispredict counters.
module br_resolve
    import br_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_is_branch_i,
    input  logic                  ex_is_jal_i,
    input  logic                  ex_is_jalr_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic                  br_less_i,
    input  logic                  br_equal_i,
    output logic                  br_unsigned_o,
    input  logic [DATA_WIDTH-1:0] ex_pc_i,
    input  logic [DATA_WIDTH-1:0] ex_imm_i,
    input  logic [DATA_WIDTH-1:0] ex_rs1_data_i,
    input  logic                  ex_pred_taken_i,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  flush_o,
    output logic                  upd_valid_o,
    output logic [DATA_WIDTH-1:0] upd_pc_o,
    output logic                  upd_taken_o,
`ifdef BR_RESOLVE_STATS_EN
    output logic [STAT_WIDTH-1:0] stat_br_cnt_o,
    output logic [STAT_WIDTH-1:0] stat_mispred_cnt_o,
`endif
    output logic                  misalign_o
);

    state_e                  state_q, state_d;
    cls_e                    cls_c;
    logic                    cond_taken_c;
    logic                    taken_c;
    logic                    mispred_c;
    logic                    accept_c;
    logic [DATA_WIDTH-1:0]   target_c;
    logic [DATA_WIDTH-1:0]   seq_pc_c;
    logic [DATA_WIDTH-1:0]   jalr_sum_c;
    logic [DATA_WIDTH-1:0]   redir_pc_c;

    logic                    redirect_valid_d;
    logic [DATA_WIDTH-1:0]   redirect_pc_d;
    logic                    flush_d;
    logic                    upd_valid_d;
    logic [DATA_WIDTH-1:0]   upd_pc_d;
    logic                    upd_taken_d;
    logic                    misalign_d;

    // Comparator mode goes straight out so the compare settles in the same cycle
    assign br_unsigned_o = ex_funct3_i[1];

    br_cond u_cond (
        .funct3  (ex_funct3_i),
        .less    (br_less_i),
        .equal   (br_equal_i),
        .taken_c (cond_taken_c)
    );

    assign cls_c    = cls_encode(ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i);
    assign accept_c = (state_q == ST_IDLE) && ex_valid_i;

    // Target, actual outcome and mispredict for the instruction in EX
    always_comb begin
        seq_pc_c   = ex_pc_i + DATA_WIDTH'(4);
        jalr_sum_c = ex_rs1_data_i + ex_imm_i;
        target_c   = ex_pc_i + ex_imm_i;
        taken_c    = 1'b0;
        mispred_c  = 1'b0;
        case (cls_c)
            CLS_BRANCH: begin
                taken_c   = cond_taken_c;
                mispred_c = cond_taken_c ^ ex_pred_taken_i;
            end
            CLS_JAL: begin
                taken_c   = 1'b1;
                mispred_c = ~ex_pred_taken_i;
            end
            CLS_JALR: begin
                target_c  = {jalr_sum_c[DATA_WIDTH-1:1], 1'b0};
                taken_c   = 1'b1;
                mispred_c = 1'b1;
            end
            default: begin
                taken_c   = 1'b0;
                mispred_c = 1'b0;
            end
        endcase
        redir_pc_c = taken_c ? target_c : seq_pc_c;
    end

    // Sequencer next state and next registered outputs
    always_comb begin
        state_d          = state_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_o;
        flush_d          = 1'b0;
        upd_valid_d      = 1'b0;
        upd_pc_d         = upd_pc_o;
        upd_taken_d      = upd_taken_o;
        misalign_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid_i) begin
                    if (mispred_c) begin
                        state_d          = ST_REDIRECT;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = redir_pc_c;
                        flush_d          = 1'b1;
                    end
                    if (cls_c == CLS_BRANCH) begin
                        upd_valid_d = 1'b1;
                        upd_pc_d    = ex_pc_i;
                        upd_taken_d = taken_c;
                    end
                    misalign_d = taken_c & target_c[1];
                end
            end
            ST_REDIRECT: begin
                state_d = ST_FLUSH2;
                flush_d = 1'b1;
            end
            ST_FLUSH2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= ST_IDLE;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            upd_valid_o      <= 1'b0;
            upd_pc_o         <= '0;
            upd_taken_o      <= 1'b0;
            misalign_o       <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_o <= redirect_valid_d;
            redirect_pc_o    <= redirect_pc_d;
            flush_o          <= flush_d;
            upd_valid_o      <= upd_valid_d;
            upd_pc_o         <= upd_pc_d;
            upd_taken_o      <= upd_taken_d;
            misalign_o       <= misalign_d;
        end
    end

`ifdef BR_RESOLVE_STATS_EN
    logic br_inc_c;
    logic misp_inc_c;

    assign br_inc_c   = accept_c && (cls_c == CLS_BRANCH);
    assign misp_inc_c = accept_c && mispred_c;

    // Saturating resolved-branch and mispredicted-transfer counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_br_cnt_o      <= '0;
            stat_mispred_cnt_o <= '0;
        end else begin
            if (br_inc_c && (stat_br_cnt_o != '1))
                stat_br_cnt_o <= stat_br_cnt_o + STAT_WIDTH'(1);
            if (misp_inc_c && (stat_mispred_cnt_o != '1))
                stat_mispred_cnt_o <= stat_mispred_cnt_o + STAT_WIDTH'(1);
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept_c;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Scoreboard bench for br_resolve: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_br_resolve;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ex_valid_i, ex_is_branch_i, ex_is_jal_i, ex_is_jalr_i;
    logic [2:0]    ex_funct3_i;
    logic          br_less_i, br_equal_i;
    logic          br_unsigned_o;
    logic [DW-1:0] ex_pc_i, ex_imm_i, ex_rs1_data_i;
    logic          ex_pred_taken_i;
    logic          redirect_valid_o;
    logic [DW-1:0] redirect_pc_o;
    logic          flush_o;
    logic          upd_valid_o;
    logic [DW-1:0] upd_pc_o;
    logic          upd_taken_o;
    logic          misalign_o;
`ifdef BR_RESOLVE_STATS_EN
    logic [31:0]   stat_br_cnt_o, stat_mispred_cnt_o;
`endif

    br_resolve #(.DATA_WIDTH(DW)) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ex_valid_i       (ex_valid_i),
        .ex_is_branch_i   (ex_is_branch_i),
        .ex_is_jal_i      (ex_is_jal_i),
        .ex_is_jalr_i     (ex_is_jalr_i),
        .ex_funct3_i      (ex_funct3_i),
        .br_less_i        (br_less_i),
        .br_equal_i       (br_equal_i),
        .br_unsigned_o    (br_unsigned_o),
        .ex_pc_i          (ex_pc_i),
        .ex_imm_i         (ex_imm_i),
        .ex_rs1_data_i    (ex_rs1_data_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .upd_valid_o      (upd_valid_o),
        .upd_pc_o         (upd_pc_o),
        .upd_taken_o      (upd_taken_o),
`ifdef BR_RESOLVE_STATS_EN
        .stat_br_cnt_o      (stat_br_cnt_o),
        .stat_mispred_cnt_o (stat_mispred_cnt_o),
`endif
        .misalign_o       (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned tgt;
        logic        rv;
        logic [31:0] rpc;
        logic        fl;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        mis;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cyc%0d %s got 0x%08h want 0x%08h", cyc, name, got, want);
        end
    endtask

    // Monitor: pop the expectation scheduled for this cycle and compare
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("redirect_valid", 32'(redirect_valid_o), 32'(e.rv));
            cmp("redirect_pc",    redirect_pc_o,         e.rpc);
            cmp("flush",          32'(flush_o),          32'(e.fl));
            cmp("upd_valid",      32'(upd_valid_o),      32'(e.uv));
            cmp("misalign",       32'(misalign_o),       32'(e.mis));
            if (e.uv) begin
                cmp("upd_pc",    upd_pc_o,          e.upc);
                cmp("upd_taken", 32'(upd_taken_o),  32'(e.ut));
            end
        end
    end

    task automatic expect_nxt(input logic rv, input logic [31:0] rpc, input logic fl,
                              input logic uv, input logic [31:0] upc, input logic ut,
                              input logic mis);
        exp_t e;
        e.tgt = cyc + 1;
        e.rv = rv; e.rpc = rpc; e.fl = fl; e.uv = uv; e.upc = upc; e.ut = ut; e.mis = mis;
        exp_q.push_back(e);
    endtask

    task automatic drv(input logic v, input logic br, input logic jal, input logic jalr,
                       input logic [2:0] f3, input logic lt, input logic eq,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                       input logic pred);
        ex_valid_i = v; ex_is_branch_i = br; ex_is_jal_i = jal; ex_is_jalr_i = jalr;
        ex_funct3_i = f3; br_less_i = lt; br_equal_i = eq;
        ex_pc_i = pc; ex_imm_i = imm; ex_rs1_data_i = rs1; ex_pred_taken_i = pred;
    endtask

    task automatic nop();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_uns(input logic want);
        #1;
        cmp("br_unsigned", 32'(br_unsigned_o), 32'(want));
    endtask

    initial begin
        rst_i = 1'b1;
        nop();
        step(); step();
        expect_nxt(0, 32'h0, 0, 0, 32'h0, 0, 0);
        step();
        rst_i = 1'b0;

        // BEQ taken, predicted not-taken: redirect to 0x120, two flush cycles
        drv(1, 1, 0, 0, 3'b000, 0, 1, 32'h100, 32'h20, 32'h0, 0);
        chk_uns(0);
        expect_nxt(1, 32'h120, 1, 1, 32'h100, 1, 0); step();
        nop(); expect_nxt(0, 32'h120, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h120, 0, 0, 32'h0, 0, 0); step();

        // BGEU taken and predicted taken: update only
        drv(1, 1, 0, 0, 3'b111, 0, 0, 32'h200, 32'h40, 32'h0, 1);
        chk_uns(1);
        expect_nxt(0, 32'h120, 0, 1, 32'h200, 1, 0); step();
        nop(); expect_nxt(0, 32'h120, 0, 0, 32'h0, 0, 0); step();

        // JALR to 0x1003 -> 0x1002, misaligned
        drv(1, 0, 0, 1, 3'b000, 0, 0, 32'h300, 32'h0, 32'h1003, 1);
        expect_nxt(1, 32'h1002, 1, 0, 32'h0, 0, 1); step();
        nop(); expect_nxt(0, 32'h1002, 1, 0, 32'h0, 0, 0); step();
        // Mispredicting branch while in FLUSH2 is wrong-path
        drv(1, 1, 0, 0, 3'b000, 0, 1, 32'h400, 32'h80, 32'h0, 0);
        expect_nxt(0, 32'h1002, 0, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h1002, 0, 0, 32'h0, 0, 0); step();

        // JAL predicted taken: nothing; JAL predicted not-taken: redirect
        drv(1, 0, 1, 0, 3'b000, 0, 0, 32'h500, 32'h10, 32'h0, 1);
        expect_nxt(0, 32'h1002, 0, 0, 32'h0, 0, 0); step();
        drv(1, 0, 1, 0, 3'b000, 0, 0, 32'h500, 32'h10, 32'h0, 0);
        expect_nxt(1, 32'h510, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h510, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h510, 0, 0, 32'h0, 0, 0); step();

        // All class bits set: JALR wins, (0x2000+0x11)&~1 = 0x2010, no update
        drv(1, 1, 1, 1, 3'b000, 0, 1, 32'h540, 32'h11, 32'h2000, 1);
        expect_nxt(1, 32'h2010, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h2010, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h2010, 0, 0, 32'h0, 0, 0); step();

        // BNE not taken, predicted taken, at 0xFFFFFFFC: fall-through wraps to 0
        drv(1, 1, 0, 0, 3'b001, 0, 1, 32'hFFFF_FFFC, 32'h8, 32'h0, 1);
        chk_uns(0);
        expect_nxt(1, 32'h0, 1, 1, 32'hFFFF_FFFC, 0, 0); step();
        nop(); expect_nxt(0, 32'h0, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h0, 0, 0, 32'h0, 0, 0); step();

        // BLT taken, predicted taken
        drv(1, 1, 0, 0, 3'b100, 1, 0, 32'h600, 32'h100, 32'h0, 1);
        expect_nxt(0, 32'h0, 0, 1, 32'h600, 1, 0); step();
        // Reserved funct3 010: never taken
        drv(1, 1, 0, 0, 3'b010, 1, 1, 32'h604, 32'h100, 32'h0, 0);
        expect_nxt(0, 32'h0, 0, 1, 32'h604, 0, 0); step();
        // Reserved funct3 011 predicted taken: mispredict to pc+4
        drv(1, 1, 0, 0, 3'b011, 1, 1, 32'h608, 32'h10, 32'h0, 1);
        expect_nxt(1, 32'h60C, 1, 1, 32'h608, 0, 0); step();
        nop(); expect_nxt(0, 32'h60C, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h60C, 0, 0, 32'h0, 0, 0); step();

        // BLTU taken to 0x706 (bit 1 set): misalign and redirect
        drv(1, 1, 0, 0, 3'b110, 1, 0, 32'h700, 32'h6, 32'h0, 0);
        chk_uns(1);
        expect_nxt(1, 32'h706, 1, 1, 32'h700, 1, 1); step();
        nop(); expect_nxt(0, 32'h706, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h706, 0, 0, 32'h0, 0, 0); step();

        // BGE not taken (less=1), predicted taken: redirect to 0x804
        drv(1, 1, 0, 0, 3'b101, 1, 0, 32'h800, 32'h40, 32'h0, 1);
        expect_nxt(1, 32'h804, 1, 1, 32'h800, 0, 0); step();
        nop(); expect_nxt(0, 32'h804, 1, 0, 32'h0, 0, 0); step();
        nop(); expect_nxt(0, 32'h804, 0, 0, 32'h0, 0, 0); step();

        // Valid non-transfer, then invalid JALR: both quiet
        drv(1, 0, 0, 0, 3'b000, 0, 1, 32'h880, 32'h4, 32'h0, 1);
        expect_nxt(0, 32'h804, 0, 0, 32'h0, 0, 0); step();
        drv(0, 0, 0, 1, 3'b000, 0, 0, 32'h884, 32'h0, 32'h3000, 0);
        expect_nxt(0, 32'h804, 0, 0, 32'h0, 0, 0); step();

        // Reset while in REDIRECT aborts the flush sequence
        drv(1, 1, 0, 0, 3'b000, 0, 1, 32'h900, 32'h4, 32'h0, 0);
        expect_nxt(1, 32'h904, 1, 1, 32'h900, 1, 0); step();
        nop(); rst_i = 1'b1;
        expect_nxt(0, 32'h0, 0, 0, 32'h0, 0, 0); step();
        rst_i = 1'b0;
        nop(); expect_nxt(0, 32'h0, 0, 0, 32'h0, 0, 0); step();
        // Back in IDLE: a correctly predicted branch updates
        drv(1, 1, 0, 0, 3'b000, 0, 0, 32'hA00, 32'h4, 32'h0, 0);
        expect_nxt(0, 32'h0, 0, 1, 32'hA00, 0, 0); step();
        nop(); expect_nxt(0, 32'h0, 0, 0, 32'h0, 0, 0); step();

        step(); step();
        cmp("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
